// File: rtl/int_multiplier_pipe.sv
// ---------------------------------------------------------------------------
// int_multiplier_pipe
//
// Fully pipelined unsigned multiplier, A_WIDTH x B_WIDTH -> A_WIDTH+B_WIDTH.
// Operand b is cut into 17-bit chunks. Tile k multiplies a by chunk k and
// adds the upper bits (>> 17) of tile k-1's product. The low 17 bits that
// each tile retires are delayed until the last tile finishes, where the
// full-width product is assembled. A valid/tag sideband runs alongside the
// data, en stalls every register, and OUT_REG adds one output register.
//
// Parameters
//   A_WIDTH   width of a (1..26)
//   B_WIDTH   width of b (1..170)
//   TAG_WIDTH width of the sideband tag
//   OUT_REG   1 = register result/out_valid/out_tag once more
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset (priority over en)
//   en         pipeline advance enable; 0 = every register holds
//   in_valid   operands valid (sampled only when en=1)
//   a, b       unsigned operands
//   in_tag     sideband returned with the result
//   out_valid  result/out_tag valid
//   result     a*b, exact
//   out_tag    tag of the operands that produced result
//
// Latency: NUM_CHUNKS + OUT_REG enabled edges, counting the sampling edge.
// ---------------------------------------------------------------------------
module int_multiplier_pipe #(
    parameter int A_WIDTH   = 24,
    parameter int B_WIDTH   = 34,
    parameter int TAG_WIDTH = 8,
    parameter int OUT_REG   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic                       out_valid,
    output logic [A_WIDTH+B_WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]       out_tag
);

    localparam int NUM_CHUNKS = (B_WIDTH + 16) / 17;
    localparam int LATENCY    = NUM_CHUNKS + OUT_REG;
    localparam int BX_WIDTH   = 17 * NUM_CHUNKS;
    localparam int P_WIDTH    = A_WIDTH + 18;
    // Meaningful bits of the last tile's product inside the final result.
    localparam int TOP_WIDTH  = A_WIDTH + B_WIDTH - 17 * (NUM_CHUNKS - 1);

    if (A_WIDTH > 26 || A_WIDTH < 1 || B_WIDTH < 1) begin : g_param_check
        $error("int_multiplier_pipe: illegal A_WIDTH=%0d / B_WIDTH=%0d (LATENCY=%0d)",
               A_WIDTH, B_WIDTH, LATENCY);
    end

    logic [BX_WIDTH-1:0]  b_ext;
    logic [A_WIDTH-1:0]   a_dly     [NUM_CHUNKS];
    logic [BX_WIDTH-1:0]  b_dly     [NUM_CHUNKS];
    logic [P_WIDTH-1:0]   mac       [NUM_CHUNKS];
    logic [P_WIDTH-1:0]   p_stage   [NUM_CHUNKS];
    logic [16:0]          low_dly   [NUM_CHUNKS][NUM_CHUNKS];
    logic                 valid_dly [NUM_CHUNKS];
    logic [TAG_WIDTH-1:0] tag_dly   [NUM_CHUNKS];
    logic [A_WIDTH+B_WIDTH-1:0] product;

    // Zero-extend b so the top chunk may be partial.
    assign b_ext = BX_WIDTH'(b);

    // Per-tile multiply-accumulate. Tile 0 uses the live operands; tile k
    // uses copies delayed by k cycles so it meets tile k-1's product.
    for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_tile
        if (k == 0) begin : g_first
            assign mac[k] = P_WIDTH'(a) * P_WIDTH'(b_ext[16:0]);
        end else begin : g_next
            assign mac[k] = P_WIDTH'(a_dly[k-1]) * P_WIDTH'(b_dly[k-1][17*k +: 17])
                          + (p_stage[k-1] >> 17);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data path is reset as well as the sideband so that
            // result reads 0 after reset without any output gating.
            for (int k = 0; k < NUM_CHUNKS; k++) begin
                a_dly[k]     <= '0;
                b_dly[k]     <= '0;
                p_stage[k]   <= '0;
                valid_dly[k] <= 1'b0;
                tag_dly[k]   <= '0;
                for (int d = 0; d < NUM_CHUNKS; d++) begin
                    low_dly[k][d] <= '0;
                end
            end
        end else if (en) begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, which is what keeps the shift
            // registers below order-independent.
            a_dly[0]     <= a;
            b_dly[0]     <= b_ext;
            valid_dly[0] <= in_valid;
            tag_dly[0]   <= in_tag;
            for (int k = 1; k < NUM_CHUNKS; k++) begin
                a_dly[k]     <= a_dly[k-1];
                b_dly[k]     <= b_dly[k-1];
                valid_dly[k] <= valid_dly[k-1];
                tag_dly[k]   <= tag_dly[k-1];
            end
            for (int k = 0; k < NUM_CHUNKS; k++) begin
                p_stage[k]    <= mac[k];
                low_dly[k][0] <= p_stage[k][16:0];
                for (int d = NUM_CHUNKS - 1; d > 0; d--) begin
                    low_dly[k][d] <= low_dly[k][d-1];
                end
            end
        end
    end

    // Tile k's low slice is ready one edge after P_k, and needs
    // NUM_CHUNKS-1-k edges in total to line up with P_{N-1}: tap N-2-k.
    for (genvar k = 0; k < NUM_CHUNKS - 1; k++) begin : g_low
        assign product[17*k +: 17] = low_dly[k][NUM_CHUNKS-2-k];
    end
    assign product[A_WIDTH+B_WIDTH-1 -: TOP_WIDTH] = p_stage[NUM_CHUNKS-1][TOP_WIDTH-1:0];

    if (OUT_REG != 0) begin : g_out_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid <= 1'b0;
                result    <= '0;
                out_tag   <= '0;
            end else if (en) begin
                out_valid <= valid_dly[NUM_CHUNKS-1];
                result    <= product;
                out_tag   <= tag_dly[NUM_CHUNKS-1];
            end
        end
    end else begin : g_out_comb
        assign out_valid = valid_dly[NUM_CHUNKS-1];
        assign result    = product;
        assign out_tag   = tag_dly[NUM_CHUNKS-1];
    end

endmodule

// File: tb/tb_int_multiplier_pipe.sv
// ---------------------------------------------------------------------------
// tb_int_multiplier_pipe
//
// Directed bench for int_multiplier_pipe. Three instances share clk/rst/en:
//   u_def : default 24x34, OUT_REG=0 (latency 2)
//   u_big : 26x51, OUT_REG=1        (latency 4)
//   u_sml : 16x10, OUT_REG=0        (latency 1)
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_int_multiplier_pipe;

    localparam int LAT_DEF = 2;
    localparam int N_RAND  = 100;

    logic clk = 1'b0;
    logic rst;
    logic en;

    logic        v_def, v_big, v_sml;
    logic [23:0] a_def;
    logic [33:0] b_def;
    logic [7:0]  t_def, t_big, t_sml;
    logic [25:0] a_big;
    logic [50:0] b_big;
    logic [15:0] a_sml;
    logic [9:0]  b_sml;

    logic        ov_def, ov_big, ov_sml;
    logic [57:0] r_def;
    logic [76:0] r_big;
    logic [25:0] r_sml;
    logic [7:0]  ot_def, ot_big, ot_sml;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    int_multiplier_pipe #(.A_WIDTH(24), .B_WIDTH(34), .TAG_WIDTH(8), .OUT_REG(0)) u_def (
        .clk(clk), .rst(rst), .en(en), .in_valid(v_def), .a(a_def), .b(b_def),
        .in_tag(t_def), .out_valid(ov_def), .result(r_def), .out_tag(ot_def));

    int_multiplier_pipe #(.A_WIDTH(26), .B_WIDTH(51), .TAG_WIDTH(8), .OUT_REG(1)) u_big (
        .clk(clk), .rst(rst), .en(en), .in_valid(v_big), .a(a_big), .b(b_big),
        .in_tag(t_big), .out_valid(ov_big), .result(r_big), .out_tag(ot_big));

    int_multiplier_pipe #(.A_WIDTH(16), .B_WIDTH(10), .TAG_WIDTH(8), .OUT_REG(0)) u_sml (
        .clk(clk), .rst(rst), .en(en), .in_valid(v_sml), .a(a_sml), .b(b_sml),
        .in_tag(t_sml), .out_valid(ov_sml), .result(r_sml), .out_tag(ot_sml));

    typedef struct {
        logic [23:0] a;
        logic [33:0] b;
        logic [7:0]  tag;
        logic [57:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [6];

    logic        h_v [N_RAND];
    logic [23:0] h_a [N_RAND];
    logic [33:0] h_b [N_RAND];
    logic [7:0]  h_t [N_RAND];

    initial begin
        logic [76:0] exp_big;
        logic [57:0] ref_p;
        int          idx;

        vecs[0] = '{a: 24'd3,       b: 34'd5,           tag: 8'h11, exp: 58'd15};
        vecs[1] = '{a: 24'hFFFFFF,  b: 34'h3_FFFF_FFFF, tag: 8'h22, exp: 58'h03FFFFFBFF000001};
        vecs[2] = '{a: 24'hFFFFFF,  b: 34'h1FFFF,       tag: 8'h33, exp: 58'h1FFFEFE0001};
        vecs[3] = '{a: 24'd0,       b: 34'h3_FFFF_FFFF, tag: 8'h44, exp: 58'd0};
        vecs[4] = '{a: 24'h123456,  b: 34'h2_0000_0001, tag: 8'h55, exp: 58'h2468AC00123456};
        vecs[5] = '{a: 24'h800000,  b: 34'h20000,       tag: 8'h66, exp: 58'h10000000000};

        rst = 1'b1; en = 1'b1;
        v_def = 1'b0; a_def = '0; b_def = '0; t_def = '0;
        v_big = 1'b0; a_big = '0; b_big = '0; t_big = '0;
        v_sml = 1'b0; a_sml = '0; b_sml = '0; t_sml = '0;
        tick(); tick();

        // Reset values.
        check("reset_valid_def", 128'(ov_def), 128'(0));
        check("reset_result_def", 128'(r_def), 128'(0));
        check("reset_tag_def", 128'(ot_def), 128'(0));
        check("reset_valid_big", 128'(ov_big), 128'(0));
        check("reset_valid_sml", 128'(ov_sml), 128'(0));
        rst = 1'b0;

        // Single pulse: valid exactly LAT_DEF edges later, then gone.
        for (int i = 0; i < 6; i++) begin
            v_def = 1'b1; a_def = vecs[i].a; b_def = vecs[i].b; t_def = vecs[i].tag;
            tick();
            v_def = 1'b0; a_def = '0; b_def = '0; t_def = '0;
            check($sformatf("vec%0d_early_valid", i), 128'(ov_def), 128'(0));
            tick();
            check($sformatf("vec%0d_valid", i), 128'(ov_def), 128'(1));
            check($sformatf("vec%0d_result", i), 128'(r_def), 128'(vecs[i].exp));
            check($sformatf("vec%0d_tag", i), 128'(ot_def), 128'(vecs[i].tag));
            tick();
            check($sformatf("vec%0d_after_valid", i), 128'(ov_def), 128'(0));
        end

        // Back-to-back random stream with bubbles.
        for (int i = 0; i < N_RAND; i++) begin
            h_v[i] = ($urandom_range(0, 3) != 0);
            h_a[i] = 24'($urandom());
            h_b[i] = 34'({$urandom(), $urandom()});
            h_t[i] = 8'($urandom());
        end
        for (int c = 0; c <= N_RAND + LAT_DEF - 2; c++) begin
            if (c < N_RAND) begin
                v_def = h_v[c]; a_def = h_a[c]; b_def = h_b[c]; t_def = h_t[c];
            end else begin
                v_def = 1'b0;
            end
            tick();
            if (c >= LAT_DEF - 1) begin
                idx = c - (LAT_DEF - 1);
                check($sformatf("rand%0d_valid", idx), 128'(ov_def), 128'(h_v[idx]));
                if (h_v[idx]) begin
                    ref_p = 58'(h_a[idx]) * 58'(h_b[idx]);
                    check($sformatf("rand%0d_result", idx), 128'(r_def), 128'(ref_p));
                    check($sformatf("rand%0d_tag", idx), 128'(ot_def), 128'(h_t[idx]));
                end
            end
        end
        v_def = 1'b0;
        tick();
        check("rand_drain_valid", 128'(ov_def), 128'(0));

        // Stall with op A at the output and op B in flight.
        v_def = 1'b1; a_def = 24'd1000; b_def = 34'd3000; t_def = 8'hA1;
        tick();
        v_def = 1'b1; a_def = 24'hABCDEF; b_def = 34'h2_0001_0000; t_def = 8'hB2;
        tick();
        en = 1'b0;
        for (int s = 0; s < 5; s++) begin
            v_def = s[0]; a_def = 24'(s + 77); b_def = 34'(s + 99); t_def = 8'hEE;
            tick();
            check($sformatf("stall%0d_valid", s), 128'(ov_def), 128'(1));
            check($sformatf("stall%0d_result", s), 128'(r_def), 128'(58'd3000000));
            check($sformatf("stall%0d_tag", s), 128'(ot_def), 128'(8'hA1));
        end
        en = 1'b1; v_def = 1'b0;
        tick();
        ref_p = 58'(24'hABCDEF) * 58'(34'h2_0001_0000);
        check("stall_b_valid", 128'(ov_def), 128'(1));
        check("stall_b_result", 128'(r_def), 128'(ref_p));
        check("stall_b_tag", 128'(ot_def), 128'(8'hB2));
        tick();
        check("stall_no_dup", 128'(ov_def), 128'(0));

        // Reset mid-flight discards the op; operands during rst are ignored.
        v_def = 1'b1; a_def = 24'd7; b_def = 34'd9; t_def = 8'h77;
        tick();
        rst = 1'b1; v_def = 1'b1; a_def = 24'd5; b_def = 34'd5; t_def = 8'h55;
        tick();
        check("rst_valid", 128'(ov_def), 128'(0));
        check("rst_result", 128'(r_def), 128'(0));
        check("rst_tag", 128'(ot_def), 128'(0));
        rst = 1'b0; v_def = 1'b1; a_def = 24'd6; b_def = 34'd7; t_def = 8'h42;
        tick();
        v_def = 1'b0;
        check("post_rst_no_ghost", 128'(ov_def), 128'(0));
        tick();
        check("post_rst_valid", 128'(ov_def), 128'(1));
        check("post_rst_result", 128'(r_def), 128'(42));
        check("post_rst_tag", 128'(ot_def), 128'(8'h42));
        tick();
        check("post_rst_drain", 128'(ov_def), 128'(0));

        // Wide instance: three tiles plus output register, latency 4.
        exp_big = {77{1'b1}} - (77'(1) << 51) - (77'(1) << 26) + 77'd2;
        v_big = 1'b1; a_big = {26{1'b1}}; b_big = {51{1'b1}}; t_big = 8'hC3;
        tick();
        v_big = 1'b0; a_big = '0; b_big = '0;
        tick(); tick();
        check("big_early_valid", 128'(ov_big), 128'(0));
        tick();
        check("big_valid", 128'(ov_big), 128'(1));
        check("big_result", 128'(r_big), 128'(exp_big));
        check("big_tag", 128'(ot_big), 128'(8'hC3));
        tick();
        check("big_after_valid", 128'(ov_big), 128'(0));

        // Narrow instance: single tile, latency 1.
        v_sml = 1'b1; a_sml = 16'hFFFF; b_sml = 10'h3FF; t_sml = 8'h5A;
        tick();
        v_sml = 1'b0;
        check("sml_valid", 128'(ov_sml), 128'(1));
        check("sml_result", 128'(r_sml), 128'(26'h3FEFC01));
        check("sml_tag", 128'(ot_sml), 128'(8'h5A));
        tick();
        check("sml_after_valid", 128'(ov_sml), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
